seg_disp_arbiter: RTL and testbench

- Shares the 8-digit seven-segment display between two requesters:
  - CPU MMIO store path, which uses a one-cycle write strobe.
  - Switch-echo path, which uses a level request plus 16-bit switch data.
- Generates the digit-scan timing and delivers a frame-stable 32-bit value, digit index and one-hot anode to the downstream segment decoder.
- Sits between the MMIO decode / switch input logic and the segment decoder.

---
 rtl/seg_disp_pkg.sv | 21 ++
 rtl/seg_disp_arbiter_if.sv | 40 ++++
 rtl/seg_scan_timer.sv | 56 +++++
 rtl/seg_disp_arbiter.sv | 119 +++++++++++
 tb/tb_seg_disp_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_disp_pkg
//  Purpose  : Shared types and constants for the seven-segment display
//             arbiter slice. Holds the owner encoding and the digit geometry.
//  Revision : 1.0 - initial release
// ============================================================================
package seg_disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 3;

    // Who currently drives the display.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_SW   = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/seg_disp_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_disp_arbiter_if
//  Purpose  : Bundles the requester inputs (CPU store strobe, switch echo)
//             and the display-side outputs of the display arbiter.
//  Ports    : master - requesters / downstream decoder side
//                      drives cpu_wr, cpu_wdata, sw_req, sw_data
//                      sees   disp_value, digit_sel, an, scan_tick, owner,
//                             cpu_hold
//             slave  - arbiter side (mirror of master)
//  Revision : 1.0 - initial release
// ============================================================================
interface seg_disp_arbiter_if
    import seg_disp_pkg::*;
    ();

    logic                  cpu_wr;
    logic [31:0]           cpu_wdata;
    logic                  sw_req;
    logic [15:0]           sw_data;

    logic [31:0]           disp_value;
    logic [DIGIT_W-1:0]    digit_sel;
    logic [NUM_DIGITS-1:0] an;
    logic                  scan_tick;
    logic [1:0]            owner;
    logic                  cpu_hold;

    modport master (
        output cpu_wr, cpu_wdata, sw_req, sw_data,
        input  disp_value, digit_sel, an, scan_tick, owner, cpu_hold
    );

    modport slave (
        input  cpu_wr, cpu_wdata, sw_req, sw_data,
        output disp_value, digit_sel, an, scan_tick, owner, cpu_hold
    );

endinterface
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_timer
//  Purpose  : Digit-scan timebase. A prescaler divides clk by SCAN_DIV; each
//             wrap advances the digit counter, which cycles over all digits.
//  Ports    : clk, rst    - clock, synchronous active-high reset
//             scan_tick   - high on the last prescaler count of a slot
//             digit_sel   - current digit index
//             an          - one-hot digit enable (1 << digit_sel)
//             frame_end   - scan_tick on the last digit of the frame
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_timer
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    output logic                       scan_tick,
    output logic [DIGIT_W-1:0]         digit_sel,
    output logic [NUM_DIGITS-1:0]      an,
    output logic                       frame_end
);

    localparam int                  c_presc_w    = $clog2(SCAN_DIV);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(SCAN_DIV - 1);
    localparam logic [DIGIT_W-1:0]   c_last_digit = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_one    = NUM_DIGITS'(1);

    logic [c_presc_w-1:0] r_presc;
    logic [DIGIT_W-1:0]   r_digit;
    logic                 w_wrap;

    assign w_wrap = (r_presc == c_presc_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (w_wrap) begin
            r_presc <= '0;
            // NUM_DIGITS is a power of two, so natural overflow is modulo 8.
            r_digit <= r_digit + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign scan_tick = w_wrap;
    assign digit_sel = r_digit;
    assign an        = c_an_one << r_digit;
    assign frame_end = w_wrap && (r_digit == c_last_digit);

endmodule
`default_nettype wire

// File: rtl/seg_disp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : seg_disp_arbiter
//  Purpose  : Shares the 8-digit seven-segment display between the CPU MMIO
//             store path and the switch-echo path, and produces frame-stable
//             display data plus digit-scan timing for the segment decoder.
//  Ports    : clk            - system clock
//             rst            - synchronous active-high reset
//             bus (slave)    - cpu_wr/cpu_wdata  CPU write strobe and value
//                              sw_req/sw_data    switch request and value
//                              disp_value        value shown this frame
//                              digit_sel/an      digit index / one-hot enable
//                              scan_tick         pulse at each digit advance
//                              owner             0=IDLE 1=SW 2=CPU
//                              cpu_hold          CPU hold counter nonzero
//  Revision : 1.0 - initial release
// ============================================================================
module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_FRAMES = 250
) (
    input  wire logic         clk,
    input  wire logic         rst,
    seg_disp_arbiter_if.slave bus
);

    localparam int                  c_hold_w    = $clog2(HOLD_FRAMES + 1);
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_FRAMES);

    logic                  w_scan_tick;
    logic [DIGIT_W-1:0]    w_digit_sel;
    logic [NUM_DIGITS-1:0] w_an;
    logic                  w_frame_end;

    owner_e                r_owner;
    owner_e                w_owner_nxt;
    logic [c_hold_w-1:0]   r_hold;
    logic [31:0]           r_shadow;
    logic [31:0]           r_disp;
    logic [31:0]           w_disp_src;

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .scan_tick (w_scan_tick),
        .digit_sel (w_digit_sel),
        .an        (w_an),
        .frame_end (w_frame_end)
    );

    // Next owner. A CPU write always wins; the CPU only yields at a frame
    // boundary once its hold has fully expired and the switch path is asking.
    always_comb begin
        w_owner_nxt = r_owner;
        case (r_owner)
            OWN_IDLE: begin
                if (bus.cpu_wr)      w_owner_nxt = OWN_CPU;
                else if (bus.sw_req) w_owner_nxt = OWN_SW;
            end
            OWN_SW: begin
                if (bus.cpu_wr)       w_owner_nxt = OWN_CPU;
                else if (!bus.sw_req) w_owner_nxt = OWN_IDLE;
            end
            OWN_CPU: begin
                if (!bus.cpu_wr && w_frame_end && (r_hold == '0) && bus.sw_req)
                    w_owner_nxt = OWN_SW;
            end
            default: w_owner_nxt = OWN_IDLE;
        endcase
    end

    // Frame load source follows the owner after this cycle's transition.
    // A write landing on frame_end is shown immediately (write-through).
    always_comb begin
        w_disp_src = 32'd0;
        case (w_owner_nxt)
            OWN_SW:  w_disp_src = {16'd0, bus.sw_data};
            OWN_CPU: w_disp_src = bus.cpu_wr ? bus.cpu_wdata : r_shadow;
            default: w_disp_src = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= OWN_IDLE;
            r_hold   <= '0;
            r_shadow <= 32'd0;
            r_disp   <= 32'd0;
        end else begin
            r_owner <= w_owner_nxt;

            // A write reloads the hold; it takes priority over the
            // frame-end decrement, which saturates at zero.
            if (bus.cpu_wr) begin
                r_shadow <= bus.cpu_wdata;
                r_hold   <= c_hold_load;
            end else if (w_frame_end && (r_hold != '0)) begin
                r_hold   <= r_hold - 1'b1;
            end

            if (w_frame_end) begin
                r_disp <= w_disp_src;
            end
        end
    end

    assign bus.disp_value = r_disp;
    assign bus.digit_sel  = w_digit_sel;
    assign bus.an         = w_an;
    assign bus.scan_tick  = w_scan_tick;
    assign bus.owner      = r_owner;
    assign bus.cpu_hold   = (r_hold != '0);

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_disp_arbiter
//  Purpose  : Self-checking bench for seg_disp_arbiter with SCAN_DIV=4,
//             HOLD_FRAMES=2 (32-cycle frames). A behavioural model derives
//             scan timing from the cycle count since reset and tracks owner,
//             hold frames, shadow and displayed value.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_disp_arbiter;

    localparam int SCAN_DIV    = 4;
    localparam int HOLD_FRAMES = 2;
    localparam int FRAME       = 8 * SCAN_DIV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_disp_arbiter_if bus ();

    seg_disp_arbiter #(
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          m_t;       // clock edges since reset
    int          m_owner;   // 0 idle, 1 switch, 2 cpu
    int          m_hold;    // remaining hold frames
    logic [31:0] m_shadow;
    logic [31:0] m_disp;

    function automatic int exp_digit();
        return (m_t / SCAN_DIV) % 8;
    endfunction

    function automatic logic exp_tick();
        return (m_t % SCAN_DIV) == SCAN_DIV - 1;
    endfunction

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic cycle();
        logic        r, w, s;
        logic [31:0] wd;
        logic [15:0] sd;
        logic        fe;
        int          nxt;
        r  = rst;
        w  = bus.cpu_wr;
        wd = bus.cpu_wdata;
        s  = bus.sw_req;
        sd = bus.sw_data;
        @(posedge clk);
        if (r) begin
            m_t = 0; m_owner = 0; m_hold = 0; m_shadow = '0; m_disp = '0;
        end else begin
            fe  = (m_t % FRAME) == FRAME - 1;
            nxt = m_owner;
            if (w)                                              nxt = 2;
            else if (m_owner == 0 && s)                         nxt = 1;
            else if (m_owner == 1 && !s)                        nxt = 0;
            else if (m_owner == 2 && fe && m_hold == 0 && s)    nxt = 1;
            if (w) begin
                m_shadow = wd;
                m_hold   = HOLD_FRAMES;
            end else if (fe && m_hold > 0) begin
                m_hold = m_hold - 1;
            end
            if (fe) m_disp = (nxt == 2) ? m_shadow : (nxt == 1) ? {16'h0, sd} : 32'h0;
            m_owner = nxt;
            m_t     = m_t + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cpu_wr = 1'b0; bus.cpu_wdata = $urandom; bus.sw_req = 1'b0; bus.sw_data = 16'($urandom);
        cycle();
        cycle();
        rst = 1'b0;
        total++; if (bus.disp_value !== 32'h0) begin bad++; $display("FAIL reset_disp got=%h exp=%h", bus.disp_value, 32'h0); end
        total++; if (bus.digit_sel !== 3'd0)   begin bad++; $display("FAIL reset_digit got=%0d exp=0", bus.digit_sel); end
        total++; if (bus.an !== 8'h01)         begin bad++; $display("FAIL reset_an got=%h exp=01", bus.an); end
        total++; if (bus.scan_tick !== 1'b0)   begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.scan_tick); end
        total++; if (bus.owner !== 2'd0)       begin bad++; $display("FAIL reset_owner got=%0d exp=0", bus.owner); end
        total++; if (bus.cpu_hold !== 1'b0)    begin bad++; $display("FAIL reset_hold got=%b exp=0", bus.cpu_hold); end
    endtask

    task automatic test_idle_scan();
        logic [7:0] e_an;
        int ticks = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            e_an = 8'(1 << exp_digit());
            if (bus.scan_tick === 1'b1) ticks++;
            total++; if (bus.an !== e_an) begin bad++; $display("FAIL idle_an t=%0d got=%h exp=%h", m_t, bus.an, e_an); end
            total++; if (bus.scan_tick !== exp_tick()) begin bad++; $display("FAIL idle_tick t=%0d got=%b exp=%b", m_t, bus.scan_tick, exp_tick()); end
            total++; if (bus.owner !== 2'd0 || bus.disp_value !== 32'h0) begin
                bad++; $display("FAIL idle_state t=%0d owner=%0d disp=%h exp owner=0 disp=0", m_t, bus.owner, bus.disp_value);
            end
        end
        total++; if (ticks != 40 / SCAN_DIV) begin bad++; $display("FAIL idle_tick_count got=%0d exp=%0d", ticks, 40 / SCAN_DIV); end
    endtask

    task automatic test_sw_path();
        bus.sw_req  = 1'b1;
        bus.sw_data = 16'h1234;
        cycle();
        total++; if (bus.owner !== 2'd1) begin bad++; $display("FAIL sw_owner got=%0d exp=1", bus.owner); end
        for (int i = 0; i <= FRAME; i++) begin
            cycle();
            total++; if (bus.disp_value !== m_disp) begin bad++; $display("FAIL sw_disp t=%0d got=%h exp=%h", m_t, bus.disp_value, m_disp); end
            if (m_t % FRAME == 0) break;
        end
        total++; if (bus.disp_value !== 32'h00001234) begin bad++; $display("FAIL sw_loaded got=%h exp=00001234", bus.disp_value); end
    endtask

    task automatic test_cpu_preempt();
        int fes = 0;
        int wait_n = $urandom_range(0, 20);
        for (int i = 0; i < wait_n; i++) cycle();
        bus.cpu_wr = 1'b1; bus.cpu_wdata = 32'hDEADBEEF;
        cycle();
        bus.cpu_wr = 1'b0; bus.cpu_wdata = $urandom;
        total++; if (bus.owner !== 2'd2 || bus.cpu_hold !== 1'b1) begin
            bad++; $display("FAIL preempt_owner owner=%0d hold=%b exp owner=2 hold=1", bus.owner, bus.cpu_hold);
        end
        for (int i = 0; i < 4 * FRAME && fes < 3; i++) begin
            cycle();
            total++; if (bus.owner !== 2'(m_owner) || bus.disp_value !== m_disp || bus.cpu_hold !== (m_hold != 0)) begin
                bad++; $display("FAIL preempt_track t=%0d owner=%0d disp=%h hold=%b exp owner=%0d disp=%h hold=%b",
                                m_t, bus.owner, bus.disp_value, bus.cpu_hold, m_owner, m_disp, m_hold != 0);
            end
            if (m_t % FRAME == 0) begin
                fes++;
                if (fes == 1) begin
                    total++; if (bus.disp_value !== 32'hDEADBEEF) begin bad++; $display("FAIL preempt_disp got=%h exp=deadbeef", bus.disp_value); end
                end
                if (fes < 3) begin
                    total++; if (bus.owner !== 2'd2) begin bad++; $display("FAIL preempt_held fe=%0d got=%0d exp=2", fes, bus.owner); end
                end
            end
        end
        total++; if (bus.owner !== 2'd1 || bus.disp_value !== 32'h00001234) begin
            bad++; $display("FAIL preempt_return owner=%0d disp=%h exp owner=1 disp=00001234", bus.owner, bus.disp_value);
        end
    endtask

    task automatic test_wr_at_frame_end();
        logic [31:0] wd = $urandom;
        int owners[3];
        int fes = 0;
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) cycle();
        bus.cpu_wr = 1'b1; bus.cpu_wdata = wd;
        cycle();
        bus.cpu_wr = 1'b0;
        total++; if (bus.disp_value !== wd || bus.owner !== 2'd2) begin
            bad++; $display("FAIL wt_disp disp=%h owner=%0d exp disp=%h owner=2", bus.disp_value, bus.owner, wd);
        end
        for (int i = 0; i < 4 * FRAME && fes < 3; i++) begin
            cycle();
            if (m_t % FRAME == 0) begin owners[fes] = int'(bus.owner); fes++; end
        end
        total++; if (fes != 3 || owners[0] != 2 || owners[1] != 2 || owners[2] != 1) begin
            bad++; $display("FAIL wt_handover fes=%0d owners=%0d,%0d,%0d exp 3 frames owners=2,2,1", fes, owners[0], owners[1], owners[2]);
        end
    endtask

    task automatic test_rst_mid();
        bus.sw_req = 1'b0;
        bus.cpu_wr = 1'b1; bus.cpu_wdata = $urandom;
        cycle();
        bus.cpu_wr = 1'b0;
        for (int i = 0; i < 33 + int'($urandom_range(0, 10)); i++) cycle();
        total++; if (bus.owner !== 2'd2) begin bad++; $display("FAIL rstmid_pre owner=%0d exp=2", bus.owner); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        total++; if (bus.disp_value !== 32'h0 || bus.digit_sel !== 3'd0 || bus.an !== 8'h01 ||
                     bus.scan_tick !== 1'b0 || bus.owner !== 2'd0 || bus.cpu_hold !== 1'b0) begin
            bad++; $display("FAIL rstmid disp=%h digit=%0d an=%h tick=%b owner=%0d hold=%b exp 0,0,01,0,0,0",
                            bus.disp_value, bus.digit_sel, bus.an, bus.scan_tick, bus.owner, bus.cpu_hold);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) cycle();
        bus.cpu_wr = 1'b1; bus.sw_req = 1'b1; bus.cpu_wdata = $urandom; bus.sw_data = 16'($urandom);
        cycle();
        bus.cpu_wr = 1'b0;
        total++; if (bus.owner !== 2'd2) begin bad++; $display("FAIL simul_owner got=%0d exp=2", bus.owner); end
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 19; i++) begin
                cycle();
                total++; if (bus.owner !== 2'd2 || bus.cpu_hold !== 1'b1 || bus.disp_value !== m_disp) begin
                    bad++; $display("FAIL simul_hold t=%0d owner=%0d hold=%b disp=%h exp owner=2 hold=1 disp=%h",
                                    m_t, bus.owner, bus.cpu_hold, bus.disp_value, m_disp);
                end
            end
            bus.cpu_wr = 1'b1; bus.cpu_wdata = $urandom;
            cycle();
            bus.cpu_wr = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [7:0] e_an;
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 599) == 0);
            bus.cpu_wr  = ($urandom_range(0, 39) == 0);
            bus.cpu_wdata = $urandom;
            if ($urandom_range(0, 24) == 0) bus.sw_req = ~bus.sw_req;
            if ($urandom_range(0, 9) == 0)  bus.sw_data = 16'($urandom);
            cycle();
            e_an = 8'(1 << exp_digit());
            total++; if (bus.owner !== 2'(m_owner)) begin bad++; $display("FAIL rnd_owner t=%0d got=%0d exp=%0d", m_t, bus.owner, m_owner); end
            total++; if (bus.disp_value !== m_disp) begin bad++; $display("FAIL rnd_disp t=%0d got=%h exp=%h", m_t, bus.disp_value, m_disp); end
            total++; if (bus.cpu_hold !== (m_hold != 0)) begin bad++; $display("FAIL rnd_hold t=%0d got=%b exp=%b", m_t, bus.cpu_hold, m_hold != 0); end
            total++; if (bus.an !== e_an || bus.digit_sel !== 3'(exp_digit())) begin
                bad++; $display("FAIL rnd_scan t=%0d an=%h digit=%0d exp an=%h digit=%0d", m_t, bus.an, bus.digit_sel, e_an, exp_digit());
            end
            total++; if (bus.scan_tick !== exp_tick()) begin bad++; $display("FAIL rnd_tick t=%0d got=%b exp=%b", m_t, bus.scan_tick, exp_tick()); end
        end
        rst = 1'b0;
        bus.cpu_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_wr = 1'b0; bus.cpu_wdata = '0; bus.sw_req = 1'b0; bus.sw_data = '0;
        m_t = 0; m_owner = 0; m_hold = 0; m_shadow = '0; m_disp = '0;
        test_reset();
        test_idle_scan();
        test_sw_path();
        test_cpu_preempt();
        test_wr_at_frame_end();
        test_rst_mid();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
